// File: rtl/ring_inject_arbiter.sv
// Packet-atomic round-robin injection arbiter feeding one ring router local port with credit tracking.
// Optional per-requester tail counters on pkt_count when RING_INJECT_ARB_STATS_EN is defined.
module ring_inject_arbiter #(
   parameter int NUM_REQ           = 4,
   parameter int FLIT_WIDTH        = 128,
   parameter int DEST_WIDTH        = 6,
   parameter int FLIT_BUFFER_DEPTH = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_REQ-1:0]                    req_valid,
   output logic [NUM_REQ-1:0]                    req_ready,
   input  logic [NUM_REQ-1:0][FLIT_WIDTH-1:0]    req_data,
   input  logic [NUM_REQ-1:0][DEST_WIDTH-1:0]    req_dest,
   input  logic [NUM_REQ-1:0]                    req_is_tail,
   output logic [FLIT_WIDTH-1:0]                 data_out,
   output logic [DEST_WIDTH-1:0]                 dest_out,
   output logic                                  is_tail_out,
   output logic                                  send_out,
   input  logic                                  credit_in,
   output logic                                  credit_err
`ifdef RING_INJECT_ARB_STATS_EN
   ,
   output logic [NUM_REQ-1:0][15:0]              pkt_count
`endif
);

   localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CW-1:0] CREDIT_FULL = CW'(FLIT_BUFFER_DEPTH);
   localparam logic [CW-1:0] CREDIT_ONE  = CW'(1);
   localparam logic [IW-1:0] LAST_ID     = IW'(NUM_REQ - 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t        state;
   logic [IW-1:0] lock_id;
   logic [IW-1:0] rr_ptr;
   logic [CW-1:0] credits;

   logic [IW-1:0] grant_id;
   logic          grant_en;
   logic          accept;
   logic          accept_tail;
   logic [IW-1:0] next_ptr;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant_id = lock_id;
      grant_en = 1'b1;
      if (state == IDLE) begin
         grant_id = '0;
         grant_en = 1'b0;
         // Walk offsets from farthest to nearest so the nearest valid requester wins.
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
               grant_id = IW'((int'(rr_ptr) + k) % NUM_REQ);
               grant_en = 1'b1;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && grant_en && (credits != '0))
         req_ready[grant_id] = 1'b1;
   end

   assign accept      = |(req_valid & req_ready);
   assign accept_tail = accept & req_is_tail[grant_id];
   assign next_ptr    = (grant_id == LAST_ID) ? '0 : grant_id + IW'(1);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits    <= CREDIT_FULL;
         credit_err <= 1'b0;
      end else begin
         case ({accept, credit_in})
            2'b10: credits <= credits - CREDIT_ONE;
            2'b01: begin
               if (credits == CREDIT_FULL)
                  credit_err <= 1'b1;
               else
                  credits <= credits + CREDIT_ONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         lock_id <= '0;
         rr_ptr  <= '0;
      end else if (accept) begin
         if (req_is_tail[grant_id]) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
         end else begin
            state   <= LOCKED;
            lock_id <= grant_id;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         send_out    <= 1'b0;
         data_out    <= '0;
         dest_out    <= '0;
         is_tail_out <= 1'b0;
      end else begin
         send_out <= accept;
         if (accept) begin
            data_out    <= req_data[grant_id];
            dest_out    <= req_dest[grant_id];
            is_tail_out <= req_is_tail[grant_id];
         end
      end
   end

`ifdef RING_INJECT_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pkt_count <= '0;
      else if (accept_tail)
         pkt_count[grant_id] <= pkt_count[grant_id] + 16'd1;
   end
`else
   logic unused_tail;
   assign unused_tail = accept_tail;
`endif

endmodule
